// File: rtl/ps2_key_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_key_rx_pkg;

  localparam int FILTER_DEF  = 8;
  localparam int TIMEOUT_DEF = 5600;

  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_E1  = 8'hE1;

  // Keyboard housekeeping bytes that never map to a key event
  localparam int N_DISCARD = 7;
  localparam logic [N_DISCARD-1:0][7:0] DISCARD_CODES =
    {PFX_E1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} fstate_t;

  typedef struct packed {
    logic       valid;
    logic       fault;
    logic [7:0] data;
  } frame_t;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) hit |= (b == DISCARD_CODES[i]);
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_rx_frame.sv
// Line conditioning (sync + stability filter) and 11-bit PS/2 frame capture
// with an inactivity timeout. Emits one registered valid or fault pulse per frame.
module ps2_frame
  import ps2_key_rx_pkg::*;
#(
  parameter int FILTER  = FILTER_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   ps2Ck,
  input  logic   ps2D,
  output frame_t o_frm
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // lane 0 = clock line, lane 1 = data line
  logic [1:0]         w_raw;
  logic [1:0]         r_s1, r_s2, r_flt;
  logic [1:0][FW-1:0] r_fcnt;
  logic               r_ck_d;
  logic               w_fall, w_d;

  assign w_raw  = {ps2D, ps2Ck};
  assign w_fall = r_ck_d & ~r_flt[0];
  assign w_d    = r_flt[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1   <= '1;
      r_s2   <= '1;
      r_flt  <= '1;
      r_fcnt <= '0;
      r_ck_d <= 1'b1;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_ck_d <= r_flt[0];
      for (int i = 0; i < 2; i++) begin
        // any sample equal to the current level restarts the run
        if (r_s2[i] == r_flt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER - 1)) begin
          r_flt[i]  <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  fstate_t       r_st;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_par;
  logic [TW-1:0] r_to;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st  <= IDLE;
      r_bit <= '0;
      r_sh  <= '0;
      r_par <= 1'b0;
      r_to  <= '0;
      o_frm <= '0;
    end else begin
      o_frm.valid <= 1'b0;
      o_frm.fault <= 1'b0;
      if (r_st == IDLE || w_fall) r_to <= '0;
      else                        r_to <= r_to + TW'(1);

      case (r_st)
        IDLE: if (w_fall && !w_d) begin
          r_st  <= DATA;
          r_bit <= '0;
        end
        DATA: if (w_fall) begin
          r_sh  <= {w_d, r_sh[7:1]};
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_st <= PARITY;
        end
        PARITY: if (w_fall) begin
          r_par <= w_d;
          r_st  <= STOP;
        end
        STOP: if (w_fall) begin
          r_st <= IDLE;
          if (w_d && ^{r_sh, r_par}) begin
            o_frm.valid <= 1'b1;
            o_frm.data  <= r_sh;
          end else begin
            o_frm.fault <= 1'b1;
          end
        end
        default: r_st <= IDLE;
      endcase

      // stalled partial frame: abandon it
      if (r_st != IDLE && !w_fall && r_to == TW'(TIMEOUT - 1)) begin
        r_st        <= IDLE;
        o_frm.fault <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver top: strips F0/E0 prefixes and housekeeping bytes,
// producing one registered key event per make/break code.
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int FILTER  = FILTER_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strobe,
  output logic       pressed,
  output logic [7:0] code,
  output logic       ext,
  output logic       error
);

  frame_t     w_frm;
  logic       r_brk_f, r_ext_f;
  logic       r_stb, r_pr, r_ext;
  logic [7:0] r_code;

  ps2_frame #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_frame (
    .clock (clock),
    .reset (reset),
    .ps2Ck (ps2Ck),
    .ps2D  (ps2D),
    .o_frm (w_frm)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_brk_f <= 1'b0;
      r_ext_f <= 1'b0;
      r_stb   <= 1'b0;
      r_pr    <= 1'b0;
      r_ext   <= 1'b0;
      r_code  <= '0;
    end else begin
      r_stb <= 1'b0;
      if (w_frm.fault) begin
        r_brk_f <= 1'b0;
        r_ext_f <= 1'b0;
      end else if (w_frm.valid) begin
        if (w_frm.data == PFX_BRK)      r_brk_f <= 1'b1;
        else if (w_frm.data == PFX_EXT) r_ext_f <= 1'b1;
        else if (!is_discard(w_frm.data)) begin
          r_stb   <= 1'b1;
          r_code  <= w_frm.data;
          r_pr    <= ~r_brk_f;
          r_ext   <= r_ext_f;
          r_brk_f <= 1'b0;
          r_ext_f <= 1'b0;
        end
      end
    end
  end

  assign strobe  = r_stb;
  assign pressed = r_pr;
  assign code    = r_code;
  assign ext     = r_ext;
  assign error   = w_frm.fault;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames with a shortened bit period.
module tb_ps2_key_rx;

  localparam int HALF = 60;  // clocks per PS/2 clock phase

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Ck = 1'b1;
  logic       ps2D  = 1'b1;
  logic       strobe, pressed, ext, error;
  logic [7:0] code;

  ps2_key_rx dut (
    .clock(clock), .reset(reset), .ps2Ck(ps2Ck), .ps2D(ps2D),
    .strobe(strobe), .pressed(pressed), .code(code), .ext(ext), .error(error)
  );

  always #9 clock = ~clock;

  int total = 0, bad = 0;
  int cyc = 0;
  int n_stb = 0, n_err = 0, n_ovl = 0;
  int stb_cyc = 0, err_cyc = 0, fall_cyc = 0, stop_cyc = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (strobe) begin n_stb++; stb_cyc = cyc; end
    if (error)  begin n_err++; err_cyc = cyc; end
    if ((strobe && error) || (strobe && prev_s) || (error && prev_e)) n_ovl++;
    prev_s = strobe;
    prev_e = error;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    ps2D = b;
    wclk(HALF);
    ps2Ck    = 1'b0;
    fall_cyc = cyc;
    wclk(HALF);
    ps2Ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip);
    send_bit(1'b1);
    stop_cyc = fall_cyc;
    ps2D = 1'b1;
    wclk(40);
  endtask

  int s0, e0, dt;

  initial begin
    wclk(5);
    chk("rst_strobe", strobe, 0);
    chk("rst_error", error, 0);
    chk("rst_code", code, 0);
    chk("rst_pr_ext", {pressed, ext}, 0);
    reset = 1'b1;
    wclk(20);

    // plain make code; raw stop fall -> 2 sync + 8 filter + 2 = 12 clocks
    s0 = n_stb; e0 = n_err;
    send_frame(8'h1C);
    chk("mk_cnt", n_stb - s0, 1);
    chk("mk_code", code, 8'h1C);
    chk("mk_pr_ext", {pressed, ext}, 2'b10);
    chk("mk_lat", stb_cyc - stop_cyc, 12);
    chk("mk_err", n_err - e0, 0);

    s0 = n_stb;
    send_frame(8'hF0); send_frame(8'h1C);
    chk("brk_cnt", n_stb - s0, 1);
    chk("brk_code", code, 8'h1C);
    chk("brk_pr_ext", {pressed, ext}, 2'b00);

    s0 = n_stb;
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    chk("xbrk_cnt", n_stb - s0, 1);
    chk("xbrk_code", code, 8'h75);
    chk("xbrk_pr_ext", {pressed, ext}, 2'b01);

    // parity fault must also drop a pending break prefix
    s0 = n_stb; e0 = n_err;
    send_frame(8'hF0); send_frame(8'h1C, 1'b1);
    chk("par_err", n_err - e0, 1);
    chk("par_stb", n_stb - s0, 0);
    chk("par_lat", err_cyc - stop_cyc, 11);
    send_frame(8'h1C);
    chk("par_next_pr", pressed, 1);
    chk("par_next_cnt", n_stb - s0, 1);

    // stalled frame: start + 5 data bits then silence
    s0 = n_stb; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    wclk(6000);
    dt = err_cyc - fall_cyc;
    chk("to_err", n_err - e0, 1);
    chk("to_win", (dt >= 5605 && dt <= 5615), 1);
    chk("to_stb", n_stb - s0, 0);
    send_frame(8'h29);
    chk("to_next_code", code, 8'h29);
    chk("to_next_cnt", n_stb - s0, 1);

    // glitch and housekeeping bytes; E0 survives an intervening discard
    s0 = n_stb; e0 = n_err;
    ps2Ck = 1'b0; wclk(4); ps2Ck = 1'b1; wclk(30);
    send_frame(8'hFA); send_frame(8'hAA);
    chk("gl_stb", n_stb - s0, 0);
    chk("gl_err", n_err - e0, 0);
    send_frame(8'hE0); send_frame(8'hFA); send_frame(8'h5A);
    chk("dis_code", code, 8'h5A);
    chk("dis_pr_ext", {pressed, ext}, 2'b11);

    // reset in the middle of a frame
    s0 = n_stb; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b0;
    wclk(3);
    chk("mrst_outs", {strobe, pressed, ext, error, code}, 0);
    reset = 1'b1;
    wclk(20);
    send_frame(8'h16);
    chk("mrst_cnt", n_stb - s0, 1);
    chk("mrst_code", code, 8'h16);
    chk("mrst_err", n_err - e0, 0);

    chk("no_overlap", n_ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 The block SHALL have parameter FILTER, default 8, meaning consecutive identical samples required to accept a new ps2Ck/ps2D level.
REQ-002 The block SHALL have parameter TIMEOUT, default 5600, meaning clocks without a ps2Ck falling edge before a partial frame is aborted (100 us at 56 MHz).
REQ-003 The block SHALL have port clock, input, 1 bit: 56 MHz system clock; the block uses one clock only.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ps2Ck, input, 1 bit: raw PS/2 clock line, asynchronous to clock.
REQ-006 The block SHALL have port ps2D, input, 1 bit: raw PS/2 data line, asynchronous to clock.
REQ-007 The block SHALL have port strobe, output, 1 bit: one-clock pulse marking a new key event.
REQ-008 The block SHALL have port pressed, output, 1 bit: 1 = make, 0 = break; valid while strobe is high, held until the next event.
REQ-009 The block SHALL have port code, output, 8 bits: scan-set-2 code with prefixes removed; held until the next event.
REQ-010 The block SHALL have port ext, output, 1 bit: event was E0-prefixed; held until the next event.
REQ-011 The block SHALL have port error, output, 1 bit: one-clock pulse on a parity, stop-bit or timeout fault.

Function
REQ-012 ps2Ck and ps2D SHALL each pass through a 2-flop synchronizer, then a FILTER-sample stability filter whose output changes only after FILTER equal consecutive samples.
REQ-013 A falling edge SHALL be the filtered ps2Ck changing 1->0; filtered ps2D SHALL be sampled in that same clock.
REQ-014 The frame FSM SHALL use states IDLE, DATA, PARITY, STOP.
REQ-015 In IDLE, an edge with data 0 SHALL enter DATA; an edge with data 1 SHALL be ignored.
REQ-016 In DATA, the block SHALL shift 8 bits in LSB first, then enter PARITY after the 8th edge.
REQ-017 In PARITY, the block SHALL store the bit and enter STOP.
REQ-018 In STOP, the frame SHALL be valid only if the stop bit is 1 and data+parity has an odd count of 1s; the FSM SHALL return to IDLE in either case.
REQ-019 An invalid frame SHALL pulse error 1 clock after the stop edge, SHALL clear both prefix flags and SHALL produce no strobe.
REQ-020 Outside IDLE, a counter SHALL clear on each edge; on reaching TIMEOUT the FSM SHALL return to IDLE, pulse error once and clear the prefix flags. The counter SHALL be held at 0 in IDLE.
REQ-021 A valid byte F0 SHALL set the break flag and a valid byte E0 SHALL set the ext flag; neither SHALL strobe.
REQ-022 Valid bytes E1, FA, AA, EE, FE, 00 and FF SHALL be discarded, SHALL leave the flags unchanged and SHALL not strobe.
REQ-023 Any other valid byte SHALL load code=byte, pressed=!break, ext=ext flag, SHALL pulse strobe, and SHALL clear both flags in the same clock.
REQ-024 strobe SHALL rise exactly 2 clocks after the clock in which the stop-bit edge is detected.
REQ-025 strobe and error SHALL never both be high, and SHALL never be high for 2 consecutive clocks.
REQ-026 A frame SHALL complete in at most 11 edges; edges after STOP SHALL start a new frame only via REQ-015.

Reset
REQ-027 While reset is low, the FSM SHALL be in IDLE; the counters, shift register and flags SHALL be 0; strobe, pressed, code, ext and error SHALL be 0.
REQ-028 The synchronizer and filter outputs SHALL reset to 1 (idle bus level).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no strobe or error.

Structure
REQ-030 A shared package SHALL hold the prefix constants F0, E0 and E1, the discard-code list, and the default FILTER and TIMEOUT values.
REQ-031 The block SHALL contain one sub-module, ps2_frame, holding the synchronizer, filter, frame FSM and timeout. It SHALL output a byte, a valid pulse and a fault pulse.
REQ-032 The top level of the block SHALL hold only the prefix decoder and the output registers.

Verification
REQ-033 Frame 1C with parity 0 and stop 1, at 12 kHz -> 1 strobe; code=1C, pressed=1, ext=0; strobe 2 clocks after the stop edge.
REQ-034 Frames F0 then 1C -> 1 strobe only, code=1C, pressed=0, ext=0; E0,F0,75 -> 1 strobe, code=75, pressed=0, ext=1.
REQ-035 Frame 1C with parity flipped -> error pulse, no strobe; a following 1C -> pressed=1 (the F0 flag was cleared).
REQ-036 5 data bits sent, then ps2Ck held high for 6000 clocks -> exactly 1 error pulse at 5600 clocks; a following full frame 29 -> code=29.
REQ-037 A 4-clock low glitch on ps2Ck in IDLE, and bytes FA and AA -> no strobe and no error.
REQ-038 Reset pulsed low after the 4th data bit, then a full frame 16 -> only one strobe, code=16; all outputs 0 during reset.
